sincos_to_phase: RTL and testbench

- Inverse of the NCO sin/cos generator: converts a sign-magnitude (cos, sin) pair back to a 20-bit phase angle and magnitude.
- Uses a fully pipelined vectoring-mode CORDIC with valid tracking; accepts one sample per clock.
- Sits after the NCO/mixer path for phase detection, AGC magnitude and NCO loopback self-test.
- Angle output format is identical to the NCO angle input: 2^20 = full circle, top 2 bits = quadrant.

---
 rtl/sincos_to_phase_pkg.sv | 51 +++++
 rtl/cordic_vec_stage.sv | 69 ++++++
 rtl/sincos_to_phase.sv | 136 +++++++++++++
 tb/tb_sincos_to_phase.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sincos_to_phase_pkg.sv
// Shared widths, quadrant encoding and the CORDIC arctangent table for
// the sign-magnitude (cos, sin) to phase/magnitude converter.
package sincos_to_phase_pkg;

   localparam int IN_W    = 18;  // magnitude bits of each sign-magnitude input
   localparam int ANGLE_W = 20;  // phase word, 2^20 = full circle
   localparam int XY_W    = 21;  // signed x/y datapath width

   // Quadrant code built from the input sign bits as {qc, qs}
   typedef enum logic [1:0] {
      QUAD_I   = 2'b00,  // cos >= 0, sin >= 0
      QUAD_IV  = 2'b01,  // cos >= 0, sin <  0
      QUAD_II  = 2'b10,  // cos <  0, sin >= 0
      QUAD_III = 2'b11   // cos <  0, sin <  0
   } quad_t;

   // atan(2^-k) scaled so 2^(ANGLE_W+zguard) is a full circle.
   // The table holds the angles at 2^32 per turn; the requested scale is
   // reached by one rounded right shift.
   function automatic logic [31:0] atan_lut(input int k, input int zguard);
      logic [32:0] t;
      int          sh;
      case (k)
         0:       t = 33'd536870912;
         1:       t = 33'd316933406;
         2:       t = 33'd167458907;
         3:       t = 33'd85004756;
         4:       t = 33'd42667331;
         5:       t = 33'd21354465;
         6:       t = 33'd10679838;
         7:       t = 33'd5340245;
         8:       t = 33'd2670163;
         9:       t = 33'd1335087;
         10:      t = 33'd667544;
         11:      t = 33'd333772;
         12:      t = 33'd166886;
         13:      t = 33'd83443;
         14:      t = 33'd41722;
         15:      t = 33'd20861;
         16:      t = 33'd10430;
         17:      t = 33'd5215;
         18:      t = 33'd2608;
         19:      t = 33'd1304;
         default: t = 33'd0;
      endcase
      sh = 32 - ANGLE_W - zguard;
      t  = t + ((33'd1 << sh) >> 1);
      return 32'(t >> sh);
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation: steers y towards zero and
// accumulates the applied rotation in z. Quadrant and zero flags ride along.
module cordic_vec_stage
   import sincos_to_phase_pkg::*;
#(
   parameter int              SHIFT    = 0,
   parameter int              Z_W      = 22,
   parameter logic [Z_W-1:0]  ATAN_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_p0,
   input  logic [XY_W-1:0]   x_p0,
   input  logic [XY_W-1:0]   y_p0,
   input  logic [Z_W-1:0]    z_p0,
   input  logic              qc_p0,
   input  logic              qs_p0,
   input  logic              zero_p0,
   output logic              vld_p1,
   output logic [XY_W-1:0]   x_p1,
   output logic [XY_W-1:0]   y_p1,
   output logic [Z_W-1:0]    z_p1,
   output logic              qc_p1,
   output logic              qs_p1,
   output logic              zero_p1
);

   localparam int                     RND_I  = (1 << SHIFT) >> 1;
   localparam logic signed [Z_W-1:0]  ATAN_S = $signed(ATAN_VAL);

   logic signed [XY_W-1:0] x_s;
   logic signed [XY_W-1:0] y_s;
   logic signed [Z_W-1:0]  z_s;

   assign x_s = $signed(x_p0);
   assign y_s = $signed(y_p0);
   assign z_s = $signed(z_p0);

   // Shift by SHIFT with round-half-up; a plain arithmetic shift floors
   // every step and the bias piles up in x over the late stages.
   function automatic logic signed [XY_W-1:0] rshift(input logic signed [XY_W-1:0] v);
      logic signed [XY_W:0] t;
      t = {v[XY_W-1], v} + (XY_W+1)'(RND_I);
      return XY_W'(t >>> SHIFT);
   endfunction

   // Valid tracking, cleared on reset so in-flight samples are dropped
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= vld_p0;
   end

   // Micro-rotation: both updates use the pre-rotation x and y
   always_ff @(posedge clk) begin
      if (!y_s[XY_W-1]) begin
         x_p1 <= x_s + rshift(y_s);
         y_p1 <= y_s - rshift(x_s);
         z_p1 <= z_s + ATAN_S;
      end else begin
         x_p1 <= x_s - rshift(y_s);
         y_p1 <= y_s + rshift(x_s);
         z_p1 <= z_s - ATAN_S;
      end
      qc_p1   <= qc_p0;
      qs_p1   <= qs_p0;
      zero_p1 <= zero_p0;
   end

endmodule

// File: rtl/sincos_to_phase.sv
// Sign-magnitude (cos, sin) to phase angle and CORDIC-scaled magnitude.
// Fold to the first quadrant, run ITER vectoring stages, unfold the angle.
module sincos_to_phase
   import sincos_to_phase_pkg::*;
#(
   parameter int ITER   = 18,
   parameter int ZGUARD = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [18:0] cos_in,
   input  logic [18:0] sin_in,
   output logic        out_valid,
   output logic [19:0] angle,
   output logic [19:0] mag
);

   localparam int                        Z_W       = ANGLE_W + ZGUARD;
   localparam int                        ZRND      = (1 << ZGUARD) >> 1;
   localparam logic signed [Z_W:0]       A_MAX     = (Z_W+1)'(1 << (ANGLE_W-2));
   localparam logic [ANGLE_W-1:0]        HALF_TURN = ANGLE_W'(1 << (ANGLE_W-1));

   // Round the guarded angle to ANGLE_W bits and clamp to [0, pi/2]
   function automatic logic [ANGLE_W-1:0] round_clamp(input logic [Z_W-1:0] z);
      logic signed [Z_W:0] t;
      t = {z[Z_W-1], z} + (Z_W+1)'(ZRND);
      t = t >>> ZGUARD;
      if (t < 0)          return '0;
      else if (t > A_MAX) return A_MAX[ANGLE_W-1:0];
      else                return t[ANGLE_W-1:0];
   endfunction

   // Map a first-quadrant angle back to the quadrant of the input
   function automatic logic [ANGLE_W-1:0] unfold(input logic [ANGLE_W-1:0] a, input quad_t q);
      case (q)
         QUAD_I:   return a;
         QUAD_II:  return HALF_TURN - a;
         QUAD_III: return HALF_TURN + a;
         default:  return ANGLE_W'(0) - a;
      endcase
   endfunction

   // x is non-negative by construction; a negative value is forced to zero
   function automatic logic [ANGLE_W-1:0] mag_sat(input logic [XY_W-1:0] x);
      if (x[XY_W-1]) return '0;
      else           return x[ANGLE_W-1:0];
   endfunction

   logic              vld_p0;
   logic [XY_W-1:0]   x_p0;
   logic [XY_W-1:0]   y_p0;
   logic              qc_p0;
   logic              qs_p0;
   logic              zero_p0;

   logic              vld_pn  [0:ITER];
   logic [XY_W-1:0]   x_pn    [0:ITER];
   logic [XY_W-1:0]   y_pn    [0:ITER];
   logic [Z_W-1:0]    z_pn    [0:ITER];
   logic              qc_pn   [0:ITER];
   logic              qs_pn   [0:ITER];
   logic              zero_pn [0:ITER];

   // ---- stage 0: fold to first quadrant ----
   // Valid enters the shift chain; reset clears it
   always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= in_valid;
   end

   // Magnitudes become non-negative x/y, signs are kept for the unfold
   always_ff @(posedge clk) begin
      x_p0    <= {{(XY_W-IN_W){1'b0}}, cos_in[IN_W-1:0]};
      y_p0    <= {{(XY_W-IN_W){1'b0}}, sin_in[IN_W-1:0]};
      qc_p0   <= cos_in[IN_W];
      qs_p0   <= sin_in[IN_W];
      zero_p0 <= (cos_in[IN_W-1:0] == '0) && (sin_in[IN_W-1:0] == '0);
   end

   assign vld_pn[0]  = vld_p0;
   assign x_pn[0]    = x_p0;
   assign y_pn[0]    = y_p0;
   assign z_pn[0]    = '0;
   assign qc_pn[0]   = qc_p0;
   assign qs_pn[0]   = qs_p0;
   assign zero_pn[0] = zero_p0;

   // ---- stages 1..ITER: vectoring micro-rotations ----
   for (genvar k = 0; k < ITER; k++) begin : g_stage
      cordic_vec_stage #(
         .SHIFT    (k),
         .Z_W      (Z_W),
         .ATAN_VAL (Z_W'(atan_lut(k, ZGUARD)))
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .vld_p0  (vld_pn[k]),
         .x_p0    (x_pn[k]),
         .y_p0    (y_pn[k]),
         .z_p0    (z_pn[k]),
         .qc_p0   (qc_pn[k]),
         .qs_p0   (qs_pn[k]),
         .zero_p0 (zero_pn[k]),
         .vld_p1  (vld_pn[k+1]),
         .x_p1    (x_pn[k+1]),
         .y_p1    (y_pn[k+1]),
         .z_p1    (z_pn[k+1]),
         .qc_p1   (qc_pn[k+1]),
         .qs_p1   (qs_pn[k+1]),
         .zero_p1 (zero_pn[k+1])
      );
   end

   // ---- stage ITER+1: unfold and register outputs ----
   // Outputs only change on a valid sample and hold across bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         angle     <= '0;
         mag       <= '0;
      end else begin
         out_valid <= vld_pn[ITER];
         if (vld_pn[ITER]) begin
            if (zero_pn[ITER]) begin
               angle <= '0;
               mag   <= '0;
            end else begin
               angle <= unfold(round_clamp(z_pn[ITER]), quad_t'({qc_pn[ITER], qs_pn[ITER]}));
               mag   <= mag_sat(x_pn[ITER]);
            end
         end
      end
   end

endmodule

// File: tb/tb_sincos_to_phase.sv
// Scoreboard bench for sincos_to_phase: directed vectors, an NCO loopback
// sweep with random bubbles, and a mid-stream reset.
module tb_sincos_to_phase;

   localparam int  LAT     = 20;
   localparam int  ANG_MOD = 1 << 20;
   localparam real PI      = 3.14159265358979323846;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        in_valid = 1'b0;
   logic [18:0] cos_in   = '0;
   logic [18:0] sin_in   = '0;
   logic        out_valid;
   logic [19:0] angle;
   logic [19:0] mag;

   typedef struct {
      int ang;
      int ang_tol;
      int mag;
      int mag_tol;
      bit chk_mag;
      int t_acc;
   } exp_t;

   exp_t           exp_q[$];
   int             n_chk  = 0;
   int             n_pass = 0;
   int             cyc    = 0;
   logic [LAT-1:0] hist   = '0;
   bit             mon_en = 1'b0;

   sincos_to_phase dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .cos_in    (cos_in),
      .sin_in    (sin_in),
      .out_valid (out_valid),
      .angle     (angle),
      .mag       (mag)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input bit ok, input longint act, input longint req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h), cycle %0d", nm, act, act, req, req, cyc);
   endtask

   function automatic int cdist(input int a, input int b);
      int d;
      d = (a - b) % ANG_MOD;
      if (d < 0) d += ANG_MOD;
      if (d > ANG_MOD / 2) d = ANG_MOD - d;
      return d;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [18:0] sm(input int v);
      logic [17:0] m;
      m = (v < 0) ? 18'(-v) : 18'(v);
      return {(v < 0), m};
   endfunction

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   // Reference valid history and cycle count, as the DUT sees its inputs
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         hist = '0;
         exp_q.delete();
      end else begin
         hist = {hist[LAT-2:0], in_valid};
      end
   end

   // Monitor: valid timing every cycle, scoreboard pop on each output
   always @(negedge clk) begin
      if (mon_en) begin
         check("vld_timing", out_valid === hist[LAT-1], longint'(out_valid), longint'(hist[LAT-1]));
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1'b0, 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("latency", (cyc - e.t_acc) == LAT, cyc - e.t_acc, LAT);
               check("angle", cdist(int'(angle), e.ang) <= e.ang_tol, angle, e.ang);
               if (e.chk_mag)
                  check("mag", iabs(int'(mag) - e.mag) <= e.mag_tol, mag, e.mag);
            end
         end
      end
   end

   task automatic send(input logic [18:0] c, input logic [18:0] s, input int ea, input int at,
                       input int em, input int mt, input bit cm, input bit do_rst);
      exp_t e;
      @(posedge clk);
      #1;
      rst      = do_rst;
      in_valid = 1'b1;
      cos_in   = c;
      sin_in   = s;
      if (!do_rst) begin
         e = '{ea, at, em, mt, cm, cyc};
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rst      = 1'b0;
         in_valid = 1'b0;
         cos_in   = 19'($urandom);
         sin_in   = 19'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle(1);
      while (exp_q.size() != 0 && n < 4 * LAT) begin
         @(posedge clk);
         n++;
      end
      check("drain", exp_q.size() == 0, exp_q.size(), 0);
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid === 1'b0, longint'(out_valid), 0);
      check("rst_angle", angle === 20'h0, angle, 0);
      check("rst_mag", mag === 20'h0, mag, 0);
      mon_en = 1'b1;

      // Axis, diagonal, wrap and zero vectors, back to back
      send(sm(200000),  sm(0),       'h00000, 4, 329352, 3, 1, 0);
      send(sm(0),       sm(200000),  'h40000, 4, 329352, 3, 1, 0);
      send(sm(-200000), sm(0),       'h80000, 4, 329352, 3, 1, 0);
      send(sm(0),       sm(-200000), 'hC0000, 4, 329352, 3, 1, 0);
      send(sm(200000),  19'h40000,   'h00000, 4, 329352, 3, 1, 0);
      send(sm(200000),  sm(-1),      'h00000, 4, 329352, 3, 1, 0);
      send(sm(100000),  sm(-100000), 'hE0000, 4, 232887, 3, 1, 0);
      send(sm(-100000), sm(100000),  'h60000, 4, 232887, 3, 1, 0);
      send(sm(262143),  sm(262143),  'h20000, 4, 610498, 3, 1, 0);
      send(sm(-262143), sm(-262143), 'hA0000, 4, 610498, 3, 1, 0);
      send(sm(173205),  sm(100000),  'h15555, 4, 329352, 3, 1, 0);
      send(sm(0),       sm(0),       'h00000, 0, 0,      0, 1, 0);
      send(19'h40000,   19'h40000,   'h00000, 0, 0,      0, 1, 0);
      send(19'h40000,   sm(0),       'h00000, 0, 0,      0, 1, 0);
      idle(3);
      send(sm(-200000), sm(0),       'h80000, 4, 329352, 3, 1, 0);
      drain();

      // NCO loopback with pseudo-random bubbles
      for (int i = 0; i < 4096; i++) begin
         int  a;
         real th;
         if ($urandom_range(0, 2) == 0) idle(1);
         a  = int'($urandom_range(0, ANG_MOD - 1));
         th = 2.0 * PI * a / ANG_MOD;
         send(sm(rnd(250000.0 * $cos(th))), sm(rnd(250000.0 * $sin(th))), a, 8, 0, 0, 0, 0);
      end
      drain();

      // Leave a known nonzero output, then reset in the middle of a stream
      send(sm(0), sm(200000), 'h40000, 4, 329352, 3, 1, 0);
      drain();
      for (int i = 0; i < 10; i++) begin
         if (i[0])
            send(sm(-100000), sm(100000), 'h60000, 4, 232887, 3, 1, (i == 5));
         else
            send(sm(100000), sm(-100000), 'hE0000, 4, 232887, 3, 1, (i == 5));
         if (i == 6) begin
            @(negedge clk);
            check("midrst_out_valid", out_valid === 1'b0, longint'(out_valid), 0);
            check("midrst_angle", angle === 20'h0, angle, 0);
            check("midrst_mag", mag === 20'h0, mag, 0);
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
